ssi_framer: RTL
===============

SSI_FRAMER -- requirements
Module: ssi_framer

Interface
REQ-001 Parameter NUM_CH, default 4: number of input channels, range 1..16.
REQ-002 Parameter WIDTH, default 16: payload bits per word, range 1..32.
REQ-003 Parameter DIV, default 2: CLK cycles per serial bit, range 1..255.
REQ-004 Parameter GAP, default 1: bit periods of enforced idle between frames, range 0..15.
REQ-005 Derived constant ID_W = max(1, clog2(NUM_CH)): channel-ID header width.
REQ-006 CLK  in  1  the single clock; all logic on its rising edge.
REQ-007 RESETn  in  1  synchronous, active-low reset.
REQ-008 ENABLE  in  1  permits new frames to start.
REQ-009 IN_VALID  in  NUM_CH  per-channel word available.
REQ-010 IN_DATA  in  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
REQ-011 IN_READY  out  NUM_CH  one-hot acceptance pulse.
REQ-012 SSI_STROBE  out  1  high for every bit period of a frame.
REQ-013 SSI_DATA  out  1  serial frame data.
REQ-014 BUSY  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, HEADER, PAYLOAD, PARITY and GAP.
REQ-016 IDLE: when ENABLE=1 and IN_VALID!=0, grant one channel round-robin, assert IN_READY[g] for exactly that cycle, capture IN_DATA[g] and g on the same edge, go to HEADER.
REQ-017 Round-robin: search starts at (last_grant+1) mod NUM_CH; last_grant resets to NUM_CH-1 so that channel 0 has first priority.
REQ-018 Sources hold IN_VALID and data until IN_READY; the block never asserts IN_READY for a channel whose IN_VALID is 0.
REQ-019 First header bit SHALL appear on SSI_DATA the cycle after acceptance (latency 1); each bit is held exactly DIV cycles.
REQ-020 Frame order: ID_W header bits (g, MSB first), WIDTH payload bits (MSB first), one even-parity bit over header and payload.
REQ-021 SSI_STROBE=1 throughout HEADER, PAYLOAD and PARITY, i.e. exactly (ID_W+WIDTH+1)*DIV cycles per frame.
REQ-022 GAP: SSI_STROBE=0 and SSI_DATA=0 for GAP*DIV cycles (state skipped when GAP=0), then IDLE.
REQ-023 IDLE lasts at least one cycle, so strobe-low between frames is at least 1+GAP*DIV cycles.
REQ-024 ENABLE deasserted mid-frame: the current frame and gap complete unchanged; no further grant is issued.
REQ-025 IN_VALID changes after capture have no effect on the frame in flight.
REQ-026 Bit-period counter and bit-index counter SHALL be width-safe for DIV=255 and ID_W+WIDTH+1=37; DIV=1 gives one bit per cycle.

Reset
REQ-027 With RESETn=0 at a rising edge: state=IDLE, IN_READY=0, SSI_STROBE=0, SSI_DATA=0, BUSY=0, counters=0, last_grant=NUM_CH-1.
REQ-028 Reset mid-frame SHALL abort the frame; outputs are at reset values from the cycle after the sampled reset edge, with no partial parity bit.
REQ-029 The first grant after reset release occurs no earlier than the first edge with RESETn=1.

Structure
REQ-030 Shared package ssi_pkg holds the FSM state enum, the ID_W derivation function and the parity helper function.
REQ-031 The round-robin arbiter is a sub-module ssi_rr_arb (NUM_CH request, one-hot grant, grant index, pointer update on accept).
REQ-032 Target size is 150-300 lines of RTL with no latches and no combinational path from IN_VALID to SSI outputs.

Verification (NUM_CH=4, WIDTH=8, DIV=2, GAP=1 unless stated)
REQ-033 Single word: ch2 sends 0xA5 -> IN_READY=4'b0100 for 1 cycle; SSI_DATA bits 10,10100101,1; SSI_STROBE high for 22 cycles, then low for at least 3 cycles.
REQ-034 Fairness: all four channels valid continuously -> grant order 0,1,2,3,0 with headers 00,01,10,11,00.
REQ-035 ENABLE falls during ch1 payload bit 3 -> ch1 frame completes with correct parity; BUSY falls after the gap; no IN_READY while ENABLE=0.
REQ-036 RESETn low during PAYLOAD -> next cycle SSI_STROBE=0, SSI_DATA=0, BUSY=0; after release ch0 is granted first.
REQ-037 DIV=1, GAP=0, ch0 sends 0x00 back-to-back -> each frame has 11-cycle strobe, header 00, parity 0, and exactly 1 strobe-low cycle between frames.
REQ-038 NUM_CH=1, WIDTH=32 -> header width 1 (always 0); 34-bit frame; parity correct for 0xFFFFFFFF (parity bit 0).

Source files
------------

// File: rtl/ssi_pkg.sv
// Shared types and helpers for the SSI framer: FSM state encoding, header width
// derivation and the even-parity function.
package ssi_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHeader,
      StPayload,
      StParity,
      StGap
   } ssi_state_e;

   localparam int unsigned PAR_MAX_W = 64;

   // Channel-ID header is never narrower than one bit, even for a single channel.
   function automatic int unsigned calc_id_w(input int unsigned num_ch);
      int unsigned w;
      w = (num_ch <= 32'd2) ? 32'd1 : 32'($clog2(num_ch));
      return w;
   endfunction

   function automatic logic calc_even_parity(input logic [PAR_MAX_W-1:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/ssi_rr_arb.sv
// Round-robin arbiter: picks the first requester after the last granted channel
// and advances its pointer only when the grant is accepted.
module ssi_rr_arb #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned ID_W   = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [NUM_CH-1:0] i_req,
   input  logic              i_accept,
   output logic [NUM_CH-1:0] o_grant,
   output logic [ID_W-1:0]   o_grant_idx
);

   logic [ID_W-1:0] r_last;
   int              w_dist;
   int              w_best;

   // Distance 0 is the channel right after r_last; the smallest distance wins.
   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      w_best      = int'(NUM_CH);
      w_dist      = 0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
         w_dist = (c + int'(NUM_CH) - 1 - int'(r_last)) % int'(NUM_CH);
         if (i_req[c] && (w_dist < w_best)) begin
            w_best      = w_dist;
            o_grant     = '0;
            o_grant[c]  = 1'b1;
            o_grant_idx = ID_W'(c);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_last <= ID_W'(NUM_CH - 1);
      end else if (i_accept) begin
         r_last <= o_grant_idx;
      end
   end

endmodule

// File: rtl/ssi_framer.sv
// Multi-channel serial framer: arbitrates one word at a time and shifts out
// {channel id, payload, even parity} with a strobe, followed by an idle gap.
module ssi_framer
   import ssi_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DIV    = 2,
   parameter int unsigned GAP    = 1
) (
   input  logic                    CLK,
   input  logic                    RESETn,
   input  logic                    ENABLE,
   input  logic [NUM_CH-1:0]       IN_VALID,
   input  logic [NUM_CH*WIDTH-1:0] IN_DATA,
   output logic [NUM_CH-1:0]       IN_READY,
   output logic                    SSI_STROBE,
   output logic                    SSI_DATA,
   output logic                    BUSY
);

   localparam int unsigned ID_W   = calc_id_w(NUM_CH);
   localparam int unsigned SH_W   = ID_W + WIDTH;
   localparam int unsigned DIV_CW = 8;
   localparam int unsigned BIT_CW = 6;

   ssi_state_e        r_state;
   ssi_state_e        w_state_next;
   logic [DIV_CW-1:0] r_div_cnt;
   logic [BIT_CW-1:0] r_bit_cnt;
   logic [SH_W-1:0]   r_shift;
   logic              r_parity;
   logic [NUM_CH-1:0] w_grant;
   logic [ID_W-1:0]   w_grant_idx;
   logic [WIDTH-1:0]  w_in_word;
   logic              w_accept;
   logic              w_bit_end;
   logic              w_last_bit;

   // RESETn gates acceptance so no grant can fire during a reset cycle.
   assign w_accept   = (r_state == StIdle) && ENABLE && RESETn && (|IN_VALID);
   assign IN_READY   = w_accept ? w_grant : '0;
   assign w_bit_end  = (r_div_cnt == DIV_CW'(DIV - 1));
   assign w_last_bit = w_bit_end && (w_state_next != r_state);

   ssi_rr_arb #(
      .NUM_CH (NUM_CH),
      .ID_W   (ID_W)
   ) u_arb (
      .i_clk       (CLK),
      .i_rst_n     (RESETn),
      .i_req       (IN_VALID),
      .i_accept    (w_accept),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx)
   );

   always_comb begin
      w_in_word = '0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
         if (w_grant[c]) begin
            w_in_word = w_in_word | IN_DATA[c*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_accept) w_state_next = StHeader;
         end
         StHeader: begin
            if (w_bit_end && (r_bit_cnt == BIT_CW'(ID_W - 1))) w_state_next = StPayload;
         end
         StPayload: begin
            if (w_bit_end && (r_bit_cnt == BIT_CW'(WIDTH - 1))) w_state_next = StParity;
         end
         StParity: begin
            if (w_bit_end) w_state_next = (GAP > 0) ? StGap : StIdle;
         end
         StGap: begin
            if (w_bit_end && (r_bit_cnt == BIT_CW'(GAP - 1))) w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Header and payload sit back to back in one shift register, MSB out first.
   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         r_div_cnt <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
      end else if (w_accept) begin
         r_div_cnt <= '0;
         r_bit_cnt <= '0;
         r_shift   <= {w_grant_idx, w_in_word};
         r_parity  <= calc_even_parity(PAR_MAX_W'({w_grant_idx, w_in_word}));
      end else if (r_state != StIdle) begin
         if (w_bit_end) begin
            r_div_cnt <= '0;
            r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
            r_shift   <= r_shift << 1;
         end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      SSI_STROBE = 1'b0;
      SSI_DATA   = 1'b0;
      BUSY       = (r_state != StIdle);
      unique case (r_state)
         StHeader, StPayload: begin
            SSI_STROBE = 1'b1;
            SSI_DATA   = r_shift[SH_W-1];
         end
         StParity: begin
            SSI_STROBE = 1'b1;
            SSI_DATA   = r_parity;
         end
         default: begin
            SSI_STROBE = 1'b0;
            SSI_DATA   = 1'b0;
         end
      endcase
   end

endmodule
